// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampling UART receive path.
//
// The serial line is first passed through a two-flop synchronizer. A small FSM
// then centres on the start bit and samples each following bit in the middle of
// its period. The frame is 8N1 by default. Defining UART_RX_PARITY_EN makes it
// 8E1 and adds the PARITY state.
//
// Ports:
//   reset         async active-high reset
//   clk           system clock (rising edge)
//   sample_ENABLE one-clk oversampling tick, 16 per bit period
//   Rx_EN         receiver enable; 0 holds the FSM in IDLE
//   RxD           asynchronous serial input, idle high
//   Rx_DATA       last received byte
//   Rx_VALID      one-clk pulse after an error-free frame
//   Rx_FERROR     framing error of last frame (stop bit sampled 0)
//   Rx_PERROR     parity error of last frame (constant 0 without parity)
module uart_receiver (
   input  logic       reset,
   input  logic       clk,
   input  logic       sample_ENABLE,
   input  logic       Rx_EN,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_FERROR,
   output logic       Rx_PERROR
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t      state_q, state_d;
   logic        sync_q, sync_d;
   logic        rxs_q, rxs_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic        par_err_q, par_err_d;
   logic        perr_q, perr_d;
`endif

   always_comb begin
      sync_d  = RxD;
      rxs_d   = sync_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
      par_err_d = par_err_q;
      perr_d    = perr_q;
`endif
      if (!Rx_EN) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (sample_ENABLE) begin
         // Wraps 15 -> 0, so the counter is already cleared for the next bit.
         cnt_d = cnt_q + 4'd1;
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (!rxs_q) state_d = START;
            end
            START: begin
               // Eighth tick is mid start bit. A high line here means it was a glitch.
               if (cnt_q == 4'd7) begin
                  cnt_d   = '0;
                  bit_d   = '0;
                  state_d = rxs_q ? IDLE : DATA;
               end
            end
            DATA: begin
               if (cnt_q == 4'd15) begin
                  shreg_d = {rxs_q, shreg_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt_q == 4'd15) begin
                  par_err_d = ^{shreg_q, rxs_q};
                  state_d   = STOP;
               end
            end
`endif
            STOP: begin
               if (cnt_q == 4'd15) begin
                  data_d  = shreg_q;
                  ferr_d  = ~rxs_q;
`ifdef UART_RX_PARITY_EN
                  perr_d  = par_err_q;
                  valid_d = rxs_q & ~par_err_q;
`else
                  valid_d = rxs_q;
`endif
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q    <= 1'b1;
         rxs_q     <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         sync_q    <= sync_d;
         rxs_q     <= rxs_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_err_q <= par_err_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign Rx_DATA   = data_q;
   assign Rx_VALID  = valid_q;
   assign Rx_FERROR = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign Rx_PERROR = perr_q;
`else
   assign Rx_PERROR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver. It works with or without UART_RX_PARITY_EN
// defined. Expected bytes for Rx_VALID pulses are queued when a frame is driven
// and popped by a monitor when the pulse appears.
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       reset, clk, sample_ENABLE, Rx_EN, RxD;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID, Rx_FERROR, Rx_PERROR;

   int errors = 0;
   int checks = 0;
   int vcnt   = 0;
   int v0;
   logic       vprev = 1'b0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       par_flip;
      logic       stop;
      logic       exp_valid;
      logic       exp_ferr;
      logic       exp_perr;
   } vec_t;
   vec_t vecs[6];

   uart_receiver dut (
      .reset         (reset),
      .clk           (clk),
      .sample_ENABLE (sample_ENABLE),
      .Rx_EN         (Rx_EN),
      .RxD           (RxD),
      .Rx_DATA       (Rx_DATA),
      .Rx_VALID      (Rx_VALID),
      .Rx_FERROR     (Rx_FERROR),
      .Rx_PERROR     (Rx_PERROR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One tick every 4 clk
   initial begin
      sample_ENABLE = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         sample_ENABLE = 1'b1;
         @(negedge clk);
         sample_ENABLE = 1'b0;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Scoreboard monitor for Rx_VALID pulses
   always @(negedge clk) begin
      if (Rx_VALID === 1'b1) begin
         vcnt++;
         chk("valid_single_cycle", {31'd0, vprev}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got pulse with data %0h expected none", Rx_DATA);
         end else begin
            chk("valid_data", {24'd0, Rx_DATA}, {24'd0, exp_q.pop_front()});
         end
      end
      vprev = Rx_VALID;
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (sample_ENABLE !== 1'b1);
      end
   endtask

   task automatic drive_bit(input logic b, input int n);
      @(negedge clk);
      RxD = b;
      wait_ticks(n);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
      drive_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
      if (PAR) drive_bit((^d) ^ par_flip, 16);
      drive_bit(stop, 16);
   endtask

   // Start bit plus data bits 0..3, then half of bit 4
   task automatic partial_frame(input logic [7:0] d);
      drive_bit(1'b0, 16);
      for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
      drive_bit(d[4], 8);
   endtask

   task automatic chk_outputs(input string tag, input logic [7:0] d, input logic fe, input logic pe);
      chk({tag, "_data"}, {24'd0, Rx_DATA}, {24'd0, d});
      chk({tag, "_ferr"}, {31'd0, Rx_FERROR}, {31'd0, fe});
      chk({tag, "_perr"}, {31'd0, Rx_PERROR}, {31'd0, pe});
   endtask

   initial begin
      //           data   pflip stop  valid  ferr  perr
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, !PAR, 1'b0, PAR};
      vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      reset = 1'b1;
      Rx_EN = 1'b1;
      RxD   = 1'b1;
      repeat (3) @(negedge clk);
      chk_outputs("reset", 8'h00, 1'b0, 1'b0);
      chk("reset_valid", {31'd0, Rx_VALID}, 32'd0);
      reset = 1'b0;
      drive_bit(1'b1, 20);

      for (int i = 0; i < 6; i++) begin
         v0 = vcnt;
         if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
         send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop);
         drive_bit(1'b1, 16);
         @(negedge clk);
         chk_outputs($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_ferr, vecs[i].exp_perr);
         chk($sformatf("vec%0d_pulses", i), vcnt - v0, {31'd0, vecs[i].exp_valid});
      end

      // A 3-tick low glitch must be rejected and leave the outputs alone
      v0 = vcnt;
      drive_bit(1'b0, 3);
      drive_bit(1'b1, 24);
      @(negedge clk);
      chk_outputs("glitch", 8'hFF, 1'b0, 1'b0);
      chk("glitch_pulses", vcnt - v0, 32'd0);

      // Two back-to-back frames
      v0 = vcnt;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'hFE);
      send_frame(8'h01, 1'b0, 1'b1);
      send_frame(8'hFE, 1'b0, 1'b1);
      drive_bit(1'b1, 16);
      @(negedge clk);
      chk_outputs("b2b", 8'hFE, 1'b0, 1'b0);
      chk("b2b_pulses", vcnt - v0, 32'd2);

      // Reset during data bit 4
      v0 = vcnt;
      partial_frame(8'h5A);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_outputs("rst_mid", 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      drive_bit(1'b1, 200);
      @(negedge clk);
      chk_outputs("rst_after", 8'h00, 1'b0, 1'b0);
      chk("rst_pulses", vcnt - v0, 32'd0);
      v0 = vcnt;
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b0, 1'b1);
      drive_bit(1'b1, 16);
      @(negedge clk);
      chk_outputs("rst_c3", 8'hC3, 1'b0, 1'b0);
      chk("rst_c3_pulses", vcnt - v0, 32'd1);

      // Rx_EN drop during data bit 4
      v0 = vcnt;
      partial_frame(8'hA6);
      @(negedge clk);
      Rx_EN = 1'b0;
      repeat (2) @(negedge clk);
      RxD   = 1'b1;
      Rx_EN = 1'b1;
      drive_bit(1'b1, 200);
      @(negedge clk);
      chk_outputs("en_abort", 8'hC3, 1'b0, 1'b0);
      chk("en_abort_pulses", vcnt - v0, 32'd0);

      // A whole frame sent while disabled is ignored
      v0 = vcnt;
      Rx_EN = 1'b0;
      send_frame(8'h77, 1'b0, 1'b1);
      drive_bit(1'b1, 16);
      Rx_EN = 1'b1;
      drive_bit(1'b1, 16);
      @(negedge clk);
      chk_outputs("disabled", 8'hC3, 1'b0, 1'b0);
      chk("disabled_pulses", vcnt - v0, 32'd0);

      v0 = vcnt;
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b0, 1'b1);
      drive_bit(1'b1, 16);
      @(negedge clk);
      chk_outputs("en_c3", 8'hC3, 1'b0, 1'b0);
      chk("en_c3_pulses", vcnt - v0, 32'd1);

      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port sample_ENABLE  input  1  one-clk-wide oversampling tick from the baud controller, 16 ticks per bit period.
REQ-004 The block SHALL have port Rx_EN  input  1  receiver enable; 0 forces IDLE.
REQ-005 The block SHALL have port RxD  input  1  asynchronous serial line, idle high.
REQ-006 The block SHALL have port Rx_DATA  output  8  last received byte.
REQ-007 The block SHALL have port Rx_VALID  output  1  one-clk pulse when an error-free frame completes.
REQ-008 The block SHALL have port Rx_FERROR  output  1  framing error of the last frame, stop bit sampled 0.
REQ-009 The block SHALL have port Rx_PERROR  output  1  parity error of the last frame.

Function
REQ-010 The block SHALL pass RxD through a 2-flop synchronizer clocked by clk; all sampling uses the synchronized value rxs.
REQ-011 The block SHALL implement states IDLE, START, DATA, PARITY, STOP, each with a 4-bit tick counter cleared on state entry; the counter advances only on clk edges where sample_ENABLE=1.
REQ-012 In IDLE, on a tick with rxs=0, the block SHALL enter START.
REQ-013 In START, on the 8th tick after entry, the block SHALL enter DATA if rxs=0, otherwise return to IDLE (glitch reject) without touching outputs.
REQ-014 In DATA, on every 16th tick, the block SHALL shift rxs into the data shift register LSB-first; after the 8th bit it SHALL enter PARITY, or STOP when parity is compiled out.
REQ-015 In PARITY, on the 16th tick, the block SHALL capture rxs and compute even parity: an error exists when the XOR of the 8 data bits and the parity bit is 1; then it SHALL enter STOP.
REQ-016 In STOP, on the 16th tick, the block SHALL load Rx_DATA, Rx_FERROR (=~rxs) and Rx_PERROR in the same edge and return to IDLE, allowing a back-to-back start bit to be detected from the next tick.
REQ-017 Rx_VALID SHALL be 1 for exactly the one clk cycle following the STOP sample edge, and only if both Rx_FERROR and Rx_PERROR are 0; otherwise it stays 0.
REQ-018 Rx_DATA, Rx_FERROR and Rx_PERROR SHALL hold their values until the next STOP sample, including through Rx_EN=0 and aborted starts.
REQ-019 Rx_EN=0 SHALL force the FSM to IDLE and clear the tick counter on the next clk edge, aborting any frame in progress with no output update; Rx_EN has priority over a simultaneous tick.
REQ-020 clk edges without sample_ENABLE SHALL not change the FSM, counter or shift register.

Reset
REQ-021 Asserting reset SHALL immediately set the FSM to IDLE, counter and shift register to 0, Rx_DATA=8'h00, Rx_VALID=0, Rx_FERROR=0, Rx_PERROR=0, and both synchronizer flops to 1.
REQ-022 Reset asserted mid-frame SHALL discard the frame; after release the receiver SHALL wait in IDLE for a new start bit.

Configuration
REQ-023 When macro UART_RX_PARITY_EN is defined, the frame SHALL be 8E1 (start, 8 data, even parity, stop) with the PARITY state present.
REQ-024 When UART_RX_PARITY_EN is undefined, the frame SHALL be 8N1, the PARITY state SHALL be absent, and Rx_PERROR SHALL be constant 0.

Verification
REQ-025 With ticks every 4 clk, parity enabled, send byte 8'hA5 with parity 0 and stop 1 -> Rx_DATA=8'hA5, a single-cycle Rx_VALID pulse, both errors 0.
REQ-026 Send 8'h3C with parity bit 1 -> Rx_PERROR=1, Rx_VALID stays 0, Rx_DATA=8'h3C.
REQ-027 Send 8'h55 with stop bit 0 -> Rx_FERROR=1, Rx_VALID stays 0; a following good frame 8'h0F -> Rx_FERROR=0 and Rx_VALID pulses.
REQ-028 Drive a low glitch of 3 ticks on RxD -> FSM returns to IDLE, no output change; then two back-to-back frames 8'h01 and 8'hFE -> two Rx_VALID pulses with matching Rx_DATA.
REQ-029 Assert reset, or drop Rx_EN, during data bit 4 of a frame -> no Rx_VALID; the next full frame 8'hC3 is received correctly.
REQ-030 With UART_RX_PARITY_EN undefined, send 8N1 frame 8'h81 -> Rx_DATA=8'h81, Rx_VALID pulses, Rx_PERROR=0.
